// File: rtl/nn_pkg.sv
// Shared types and default sizes for the classifier argmax block.
package nn_pkg;

    localparam int NUM_CLASSES_DEF = 10;
    localparam int RESULT_W        = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } argmax_state_t;

endpackage

// File: rtl/argmax_cmp.sv
// Signed "candidate beats current best" compare with the build-selected tie rule.
// ARGMAX_TIE_LAST_EN: when defined, ties go to the later (higher) index.
module argmax_cmp
    import nn_pkg::*;
#(
    parameter int DATA_W = RESULT_W
) (
    input  logic signed [DATA_W-1:0] cand_i,
    input  logic signed [DATA_W-1:0] best_i,
    output logic                     take_o
);

`ifdef ARGMAX_TIE_LAST_EN
    assign take_o = (cand_i >= best_i);
`else
    assign take_o = (cand_i > best_i);
`endif

endmodule

// File: rtl/classify_argmax.sv
// Scans NUM_CLASSES signed row results one per cycle and reports the index/value of the max.
// Tie rule is selected in argmax_cmp by ARGMAX_TIE_LAST_EN (undefined: lowest tied index wins).
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for start; result registers hold the last answer
// ST_SCAN | out_sel = idx, one row compared per cycle
// ST_DONE | one-cycle done pulse, result final, back to idle
module classify_argmax
    import nn_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int DATA_W      = RESULT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     clear,
    input  logic                     ovf_in,
    output logic [3:0]               out_sel,
    input  logic signed [DATA_W-1:0] out_data,
    output logic                     busy,
    output logic                     done,
    output logic                     class_valid,
    output logic [3:0]               class_idx,
    output logic signed [DATA_W-1:0] class_value,
    output logic                     class_ovf
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

    argmax_state_t state_q, state_d;

    logic [3:0]               idx_q, idx_d;
    logic signed [DATA_W-1:0] best_val_q, best_val_d;
    logic [3:0]               best_idx_q, best_idx_d;
    logic                     ovf_cap_q, ovf_cap_d;
    logic                     valid_q, valid_d;
    logic [3:0]               res_idx_q, res_idx_d;
    logic signed [DATA_W-1:0] res_val_q, res_val_d;
    logic                     res_ovf_q, res_ovf_d;

    logic                     take;
    logic                     upd;
    logic signed [DATA_W-1:0] nb_val;
    logic [3:0]               nb_idx;

    argmax_cmp #(.DATA_W(DATA_W)) u_cmp (
        .cand_i (out_data),
        .best_i (best_val_q),
        .take_o (take)
    );

    // Row 0 seeds the best unconditionally, so all-negative inputs need no sentinel.
    assign upd    = (idx_q == 4'd0) || take;
    assign nb_val = upd ? out_data : best_val_q;
    assign nb_idx = upd ? idx_q    : best_idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start) state_d = ST_SCAN;
                ST_SCAN: if (idx_q == LAST_IDX) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_DONE);
        out_sel = (state_q == ST_SCAN) ? idx_q : 4'd0;
    end

    always_comb begin
        idx_d      = idx_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        ovf_cap_d  = ovf_cap_q;
        valid_d    = valid_q;
        res_idx_d  = res_idx_q;
        res_val_d  = res_val_q;
        res_ovf_d  = res_ovf_q;
        if (clear) begin
            idx_d   = 4'd0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        idx_d     = 4'd0;
                        ovf_cap_d = ovf_in;
                        valid_d   = 1'b0;
                    end
                end
                ST_SCAN: begin
                    best_val_d = nb_val;
                    best_idx_d = nb_idx;
                    if (idx_q == LAST_IDX) begin
                        res_val_d = nb_val;
                        res_idx_d = nb_idx;
                        res_ovf_d = ovf_cap_q;
                        valid_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
                ST_DONE: idx_d = 4'd0;
                default: idx_d = 4'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= 4'd0;
            best_val_q <= '0;
            best_idx_q <= 4'd0;
            ovf_cap_q  <= 1'b0;
            valid_q    <= 1'b0;
            res_idx_q  <= 4'd0;
            res_val_q  <= '0;
            res_ovf_q  <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            ovf_cap_q  <= ovf_cap_d;
            valid_q    <= valid_d;
            res_idx_q  <= res_idx_d;
            res_val_q  <= res_val_d;
            res_ovf_q  <= res_ovf_d;
        end
    end

    assign class_valid = valid_q;
    assign class_idx   = res_idx_q;
    assign class_value = res_val_q;
    assign class_ovf   = res_ovf_q;

endmodule

// File: tb/tb_classify_argmax.sv
// Directed bench for classify_argmax: row tables with hand-computed maxima and timing.
module tb_classify_argmax;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               clear;
    logic               ovf_in;
    logic [3:0]         out_sel;
    logic signed [15:0] out_data;
    logic               busy;
    logic               done;
    logic               class_valid;
    logic [3:0]         class_idx;
    logic signed [15:0] class_value;
    logic               class_ovf;

    int vals [10];
    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    // Result register file model: combinational, same-cycle.
    always_comb begin
        out_data = '0;
        if (out_sel < 4'd10) out_data = 16'(vals[out_sel]);
    end

    classify_argmax #(.NUM_CLASSES(10), .DATA_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .clear       (clear),
        .ovf_in      (ovf_in),
        .out_sel     (out_sel),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done),
        .class_valid (class_valid),
        .class_idx   (class_idx),
        .class_value (class_value),
        .class_ovf   (class_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start sampled at edge T; returns positioned in cycle T+1.
    task automatic pulse_start(input logic ovf);
        start  = 1'b1;
        ovf_in = ovf;
        step();
        start  = 1'b0;
        ovf_in = 1'b0;
    endtask

    // From cycle T+1, returns the cycle offset n at which done is high (-1 on timeout).
    task automatic wait_done(output int n);
        n = 1;
        while (done !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        if (done !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; clear = 1'b0; ovf_in = 1'b1;
        repeat (3) step();
        vec_cnt++;
        if ({busy, done, class_valid, class_ovf} !== 4'b0000 || out_sel !== 4'd0 ||
            class_idx !== 4'd0 || class_value !== 16'sd0) begin
            err_cnt++;
            $display("FAIL reset_state: busy=%b done=%b valid=%b ovf=%b sel=%0d idx=%0d val=%0d required all 0",
                     busy, done, class_valid, class_ovf, out_sel, class_idx, class_value);
        end
        rst = 1'b0; start = 1'b0; ovf_in = 1'b0;
        step();
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_release_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_basic();
        vals = '{5, -3, 100, 7, 0, 2, 9, -50, 99, 1};
        pulse_start(1'b0);
        for (int k = 0; k < 10; k++) begin
            vec_cnt++;
            if (out_sel !== 4'(k) || busy !== 1'b1 || done !== 1'b0 || class_valid !== 1'b0) begin
                err_cnt++;
                $display("FAIL basic_scan_step%0d: sel=%0d busy=%b done=%b valid=%b required sel=%0d busy=1 done=0 valid=0",
                         k, out_sel, busy, done, class_valid, k);
            end
            step();
        end
        vec_cnt++;
        if (done !== 1'b1 || class_valid !== 1'b1 || class_idx !== 4'd2 ||
            class_value !== 16'sd100 || out_sel !== 4'd0 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL basic_done_T11: done=%b valid=%b idx=%0d val=%0d sel=%0d busy=%b required 1 1 2 100 0 1",
                     done, class_valid, class_idx, class_value, out_sel, busy);
        end
        step();
        vec_cnt++;
        if (done !== 1'b0 || busy !== 1'b0 || class_valid !== 1'b1 || class_idx !== 4'd2 || class_value !== 16'sd100) begin
            err_cnt++;
            $display("FAIL basic_hold: done=%b busy=%b valid=%b idx=%0d val=%0d required 0 0 1 2 100",
                     done, busy, class_valid, class_idx, class_value);
        end
    endtask

    task automatic test_negative();
        int n;
        vals = '{-10, -2, -7, -3, -4, -5, -6, -8, -20, -9};
        pulse_start(1'b0);
        wait_done(n);
        vec_cnt++;
        if (n != 11 || class_idx !== 4'd1 || class_value !== -16'sd2) begin
            err_cnt++;
            $display("FAIL negative_rows: done_at=%0d idx=%0d val=%0d required 11 1 -2", n, class_idx, class_value);
        end
        step();
    endtask

    task automatic test_tie();
        int n;
        logic [3:0] exp_idx;
`ifdef ARGMAX_TIE_LAST_EN
        exp_idx = 4'd6;
`else
        exp_idx = 4'd3;
`endif
        vals = '{1, 2, 3, 32767, 4, 5, 32767, -1, 100, -32768};
        pulse_start(1'b0);
        wait_done(n);
        vec_cnt++;
        if (n != 11 || class_idx !== exp_idx || class_value !== 16'sh7FFF) begin
            err_cnt++;
            $display("FAIL tie_rule: done_at=%0d idx=%0d val=%0d required 11 %0d 32767", n, class_idx, class_value, exp_idx);
        end
        step();
    endtask

    task automatic test_busy_start();
        vals = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 50};
        pulse_start(1'b0);
        repeat (3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        vec_cnt++;
        if (done !== 1'b0) begin
            err_cnt++;
            $display("FAIL busy_start_early_done: done at T+10=%b required 0", done);
        end
        step();
        vec_cnt++;
        if (done !== 1'b1 || class_idx !== 4'd9 || class_value !== 16'sd50) begin
            err_cnt++;
            $display("FAIL busy_start_done_T11: done=%b idx=%0d val=%0d required 1 9 50", done, class_idx, class_value);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        vec_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || class_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL start_at_done_ignored: busy=%b done=%b valid=%b required 0 0 1", busy, done, class_valid);
        end
        step();
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL start_at_done_no_queue: busy=%b required 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        vals = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        pulse_start(1'b0);
        wait_done(n);
        vec_cnt++;
        if (n != 11 || class_idx !== 4'd9 || class_value !== 16'sd10) begin
            err_cnt++;
            $display("FAIL b2b_first: done_at=%0d idx=%0d val=%0d required 11 9 10", n, class_idx, class_value);
        end
        step();
        vals = '{-1, 40, 3, 4, 5, 6, 7, 8, 9, 10};
        pulse_start(1'b0);
        vec_cnt++;
        if (busy !== 1'b1 || out_sel !== 4'd0 || class_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_accept_idle_start: busy=%b sel=%0d valid=%b required 1 0 0", busy, out_sel, class_valid);
        end
        wait_done(n);
        vec_cnt++;
        if (n != 11 || class_idx !== 4'd1 || class_value !== 16'sd40) begin
            err_cnt++;
            $display("FAIL b2b_second: done_at=%0d idx=%0d val=%0d required 11 1 40", n, class_idx, class_value);
        end
        step();
    endtask

    task automatic test_ovf();
        int n;
        vals = '{5, -3, 100, 7, 0, 2, 9, -50, 99, 1};
        pulse_start(1'b1);
        wait_done(n);
        vec_cnt++;
        if (n != 11 || class_ovf !== 1'b1) begin
            err_cnt++;
            $display("FAIL ovf_captured: done_at=%0d ovf=%b required 11 1", n, class_ovf);
        end
        step();
        pulse_start(1'b0);
        wait_done(n);
        vec_cnt++;
        if (n != 11 || class_ovf !== 1'b0) begin
            err_cnt++;
            $display("FAIL ovf_cleared: done_at=%0d ovf=%b required 11 0", n, class_ovf);
        end
        step();
    endtask

    task automatic test_clear();
        int seen;
        vals = '{5, -3, 100, 7, 0, 2, 9, -50, 99, 1};
        pulse_start(1'b0);
        repeat (4) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        vec_cnt++;
        if (busy !== 1'b0 || class_valid !== 1'b0 || out_sel !== 4'd0 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL clear_mid_scan: busy=%b valid=%b sel=%0d done=%b required 0 0 0 0", busy, class_valid, out_sel, done);
        end
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            step();
        end
        vec_cnt++;
        if (seen != 0) begin
            err_cnt++;
            $display("FAIL clear_no_done: active cycles=%0d required 0", seen);
        end
        start = 1'b1; clear = 1'b1;
        step();
        start = 1'b0; clear = 1'b0;
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL clear_over_start: busy=%b required 0", busy);
        end
    endtask

    task automatic test_rst_mid();
        int n;
        int seen;
        vals = '{5, -3, 100, 7, 0, 2, 9, -50, 99, 1};
        pulse_start(1'b1);
        wait_done(n);
        step();
        pulse_start(1'b0);
        repeat (4) step();
        rst = 1'b1; clear = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; clear = 1'b0; start = 1'b0;
        vec_cnt++;
        if ({busy, done, class_valid, class_ovf} !== 4'b0000 || out_sel !== 4'd0 ||
            class_idx !== 4'd0 || class_value !== 16'sd0) begin
            err_cnt++;
            $display("FAIL rst_mid_scan: busy=%b done=%b valid=%b ovf=%b sel=%0d idx=%0d val=%0d required all 0",
                     busy, done, class_valid, class_ovf, out_sel, class_idx, class_value);
        end
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (done === 1'b1) seen++;
            step();
        end
        vec_cnt++;
        if (seen != 0) begin
            err_cnt++;
            $display("FAIL rst_no_done: done pulses=%0d required 0", seen);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; clear = 1'b0; ovf_in = 1'b0;
        vals = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        test_reset();
        test_basic();
        test_negative();
        test_tie();
        test_busy_start();
        test_back_to_back();
        test_ovf();
        test_clear();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/classify_argmax.md
CLASSIFY_ARGMAX -- requirements
Module: classify_argmax

Interface
REQ-001 Parameter NUM_CLASSES, default 10, meaning: number of result rows scanned (2..16).
REQ-002 Parameter DATA_W, default 16, meaning: signed width of each row result.
REQ-003 clk  input  1  meaning: the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  meaning: reset, synchronous and active-high.
REQ-005 start  input  1  meaning: request a scan; pulsed by the controller when done_calc rises.
REQ-006 clear  input  1  meaning: abort any scan and invalidate the result.
REQ-007 ovf_in  input  1  meaning: multiplier overflow flag, sampled with start.
REQ-008 out_sel  output  4  meaning: row index driven to the result register file.
REQ-009 out_data  input  DATA_W  meaning: signed row result for out_sel, combinational and same-cycle.
REQ-010 busy  output  1  meaning: a scan is in progress.
REQ-011 done  output  1  meaning: one-cycle pulse when the result is final.
REQ-012 class_valid  output  1  meaning: class_idx/class_value hold a completed result.
REQ-013 class_idx  output  4  meaning: index of the maximum row.
REQ-014 class_value  output  DATA_W  meaning: value of the maximum row.
REQ-015 class_ovf  output  1  meaning: ovf_in as captured at start for this result.

Function
REQ-016 The FSM SHALL have states IDLE, SCAN and DONE.
REQ-017 In IDLE, start=1 SHALL:
  - move the FSM to SCAN;
  - set idx to 0;
  - capture ovf_in;
  - clear class_valid.
REQ-018 In SCAN, out_sel SHALL equal idx, and each cycle the block SHALL compare out_data (signed) against best_value.
REQ-019 At idx=0 the block SHALL load best_value=out_data and best_idx=0 unconditionally.
REQ-020 At idx>0 the block SHALL replace the best when out_data > best_value.
REQ-021 When idx=NUM_CLASSES-1, after that compare the FSM SHALL go to DONE, and idx SHALL NOT wrap.
REQ-022 In DONE, for exactly one cycle the block SHALL:
  - assert done;
  - set class_valid=1;
  - present class_idx, class_value and class_ovf;
  - then return to IDLE.
REQ-023 Latency: start sampled at edge T SHALL produce done high during cycle T+NUM_CLASSES+1 (cycle 11 for the default).
REQ-024 busy SHALL be 1 in SCAN and DONE, and 0 in IDLE.
REQ-025 start while busy=1 SHALL be ignored, with no restart and no queuing.
REQ-026 start in the cycle done is high SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-027 clear=1 in any state SHALL force IDLE and class_valid=0, with no done pulse; clear SHALL take priority over start in the same cycle.
REQ-028 class_idx, class_value and class_ovf SHALL hold their values until the next accepted start or clear.
REQ-029 out_sel SHALL be 0 in IDLE and DONE.

Reset
REQ-030 rst=1 at a clock edge SHALL set:
  - state=IDLE, idx=0, out_sel=0;
  - busy=0, done=0, class_valid=0;
  - class_idx=0, class_value=0, class_ovf=0.
REQ-031 rst SHALL override clear and start, and reset mid-scan SHALL discard partial results with no done pulse.

Configuration
REQ-032 Macro ARGMAX_TIE_LAST_EN: when defined, replacement SHALL use out_data >= best_value, so the highest tied index wins.
REQ-033 When ARGMAX_TIE_LAST_EN is undefined, replacement SHALL use strict >, so the lowest tied index wins.

Structure
REQ-034 A shared package nn_pkg SHALL hold:
  - the state enum typedef argmax_state_t;
  - NUM_CLASSES_DEF=10;
  - RESULT_W=16.
REQ-035 A combinational sub-module argmax_cmp SHALL perform the signed compare and tie rule; everything else SHALL reside in classify_argmax.

Verification
REQ-036 Rows {5,-3,100,7,0,2,9,-50,99,1}, start at T -> out_sel steps 0..9 over cycles T+1..T+10; done at T+11 with class_idx=2, class_value=100, class_valid=1.
REQ-037 All rows negative {-10,-2,-7,...,-9} -> class_idx=1, class_value=-2, confirming signed compare with no zero default.
REQ-038 Rows 3 and 6 both equal 0x7FFF, all others smaller -> class_idx=3 without ARGMAX_TIE_LAST_EN, class_idx=6 with it.
REQ-039 Start pulses at cycle T+4 and at the done cycle, both while busy -> ignored; a single done at T+11 with the result of the first scan.
REQ-040 clear at T+5 -> IDLE at T+6, class_valid=0, no done; rst at T+5 of a new scan -> all outputs 0 at T+6.
REQ-041 ovf_in=1 at start, then 0 -> class_ovf=1 at done; a following scan with ovf_in=0 -> class_ovf=0.
